clk_rst_gen: RTL and testbench

- Parametrised successor to the fixed divide-by-2 core-clock generator used in the FPGA top level.
- Derives a divided clock from clk_i, with a divisor that software/straps can change at run time without glitches.
- Also produces a single-cycle enable pulse and a reset that is released synchronously and aligned to the divided clock.
- Sits between the board clock/reset pins and the SoC core in the FPGA top level.

---
 rtl/clk_rst_gen_pkg.sv | 23 ++
 rtl/clk_rst_gen_rst_sync.sv | 29 ++
 rtl/clk_rst_gen.sv | 152 +++++++++++++++
 tb/tb_clk_rst_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_gen_pkg
// Shared constants and helpers for the divided-clock / reset generator.
//   DIV_W_DEFAULT : default width of the divisor and the period counter
//   DIV_MIN       : smallest divisor the generator will run with
//   rel_state_e   : state of the divided-domain reset release
//   clamp_div()   : maps any requested divisor below DIV_MIN onto DIV_MIN
// -----------------------------------------------------------------------------
package clk_rst_gen_pkg;

    localparam int          DIV_W_DEFAULT = 8;
    localparam int unsigned DIV_MIN       = 2;

    typedef enum logic {
        REL_HOLD,
        REL_DONE
    } rel_state_e;

    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/clk_rst_gen_rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
// Reset synchroniser: asynchronous assertion, synchronous release after
// STAGES rising edges of clk_i. Shared by the core, UART and flash domains.
//   clk_i     : destination clock
//   reset_n   : asynchronous active-low reset
//   sync_rst_n: synchronised active-low reset (0 while in reset)
// -----------------------------------------------------------------------------
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_n,
    output logic sync_rst_n
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
        end
    end

    assign sync_rst_n = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_gen.sv
// -----------------------------------------------------------------------------
// clk_rst_gen
// Run-time programmable clock divider with a rising-edge enable pulse and a
// divided-domain reset that releases a fixed number of divided periods after
// the board reset is synchronised.
//   clk_i      : source clock
//   reset_n    : asynchronous active-low reset
//   div_i      : requested divisor N (values below 2 are treated as 2)
//   div_load_i : one-cycle request to capture div_i
//   div_busy_o : a captured divisor is waiting for the next period boundary
//   clk_o      : divided clock, high floor(N/2) / low ceil(N/2) cycles
//   clk_en_o   : one clk_i-cycle pulse coincident with each rising clk_o
//   rst_n_o    : divided-domain reset, async assert / sync release
// Build option: define CLK_RST_GEN_DUTY50_EN to stretch the high phase of
// odd divisors by half a clk_i cycle (50% duty) using a negedge flop.
// -----------------------------------------------------------------------------
module clk_rst_gen
    import clk_rst_gen_pkg::*;
#(
    parameter int DIV_W           = DIV_W_DEFAULT,
    parameter int DEFAULT_DIV     = 2,
    parameter int RST_SYNC_STAGES = 2,
    parameter int HOLD_PERIODS    = 4
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             div_load_i,
    output logic             div_busy_o,
    output logic             clk_o,
    output logic             clk_en_o,
    output logic             rst_n_o
);

    localparam int PCNT_W = $clog2(HOLD_PERIODS + 1);

    logic              run_n;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  cnt_next;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  pend_q;
    logic              busy_q;
    logic              clk_q;
    logic              clk_next;
    logic              en_q;
    logic              wrap;

    rel_state_e        state_q;
    rel_state_e        state_d;
    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;

    rst_sync #(
        .STAGES (RST_SYNC_STAGES)
    ) u_rst_sync (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .sync_rst_n (run_n)
    );

    // Counter is preset to N-1 so the first running edge wraps and starts
    // a fresh period with a rising clk_o and an enable pulse.
    always_comb begin
        wrap     = (cnt_q == (div_q - 1'b1));
        cnt_next = wrap ? '0 : (cnt_q + 1'b1);
        clk_next = (cnt_next < (div_q >> 1));
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= DIV_W'(DEFAULT_DIV - 1);
            div_q  <= DIV_W'(DEFAULT_DIV);
            pend_q <= DIV_W'(DEFAULT_DIV);
            busy_q <= 1'b0;
            clk_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            if (div_load_i) begin
                pend_q <= DIV_W'(clamp_div(32'(div_i)));
                busy_q <= 1'b1;
            end
            if (run_n) begin
                cnt_q <= cnt_next;
                clk_q <= clk_next;
                en_q  <= wrap;
                // A new divisor only takes effect at a period boundary. A load
                // landing on that same edge keeps busy set for the next wrap.
                if (wrap && busy_q) begin
                    div_q <= pend_q;
                    if (!div_load_i) begin
                        busy_q <= 1'b0;
                    end
                end
            end
        end
    end

    // Reset release: count enable pulses, release on pulse HOLD_PERIODS.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        case (state_q)
            REL_HOLD: begin
                if (run_n && wrap) begin
                    if (pcnt_q == PCNT_W'(HOLD_PERIODS)) begin
                        state_d = REL_DONE;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
            REL_DONE: begin
                state_d = REL_DONE;
            end
            default: begin
                state_d = REL_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REL_HOLD;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign rst_n_o    = (state_q == REL_DONE);
    assign div_busy_o = busy_q;
    assign clk_en_o   = en_q;

`ifdef CLK_RST_GEN_DUTY50_EN
    logic clk_neg_q;

    always_ff @(negedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            clk_neg_q <= 1'b0;
        end else begin
            clk_neg_q <= clk_q;
        end
    end

    // The half-cycle-delayed copy only extends the high phase for odd N.
    assign clk_o = clk_q | (div_q[0] & clk_neg_q);
`else
    assign clk_o = clk_q;
`endif

endmodule

// File: tb/tb_clk_rst_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_gen
// Self-checking bench for clk_rst_gen: a period-level reference model (queue
// of expected clk_o/clk_en_o samples per divided period), a table of divisor
// loads with expected period/high lengths, and directed reset sequences.
// -----------------------------------------------------------------------------
module tb_clk_rst_gen;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 2;
    localparam int STAGES  = 2;
    localparam int HOLD    = 4;

    logic             clk_i      = 1'b0;
    logic             reset_n    = 1'b0;
    logic [DIV_W-1:0] div_i      = '0;
    logic             div_load_i = 1'b0;
    logic             div_busy_o;
    logic             clk_o;
    logic             clk_en_o;
    logic             rst_n_o;

    int checks = 0;
    int errors = 0;

    clk_rst_gen #(
        .DIV_W           (DIV_W),
        .DEFAULT_DIV     (DEF_DIV),
        .RST_SYNC_STAGES (STAGES),
        .HOLD_PERIODS    (HOLD)
    ) dut (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .div_i      (div_i),
        .div_load_i (div_load_i),
        .div_busy_o (div_busy_o),
        .clk_o      (clk_o),
        .clk_en_o   (clk_en_o),
        .rst_n_o    (rst_n_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    int m_edges;      // clk_i edges seen since reset_n released
    int m_act;
    int m_pend;
    bit m_busy;
    bit m_rst;
    int m_pulses;
    bit m_clk;
    bit m_en;
    bit q_clk[$];
    bit q_en[$];

    task automatic model_reset();
        m_edges  = 0;
        m_act    = DEF_DIV;
        m_pend   = DEF_DIV;
        m_busy   = 0;
        m_rst    = 0;
        m_pulses = 0;
        m_clk    = 0;
        m_en     = 0;
        q_clk.delete();
        q_en.delete();
    endtask

    task automatic model_edge(input bit ld, input int d);
        bit old_busy;
        int old_pend;
        old_busy = m_busy;
        old_pend = m_pend;
        if (ld) begin
            m_pend = (d < 2) ? 2 : d;
            m_busy = 1;
        end
        m_edges++;
        if (m_edges > STAGES) begin
            if (q_clk.size() == 0) begin
                // a new divided period begins
                if (old_busy) begin
                    m_act = old_pend;
                    if (!ld) m_busy = 0;
                end
                for (int i = 0; i < m_act; i++) begin
                    q_clk.push_back(i < (m_act / 2));
                    q_en.push_back(i == 0);
                end
                if (m_pulses == HOLD) m_rst = 1;
                m_pulses++;
            end
            m_clk = q_clk.pop_front();
            m_en  = q_en.pop_front();
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("clk_o",      int'(clk_o),      int'(m_clk));
        check("clk_en_o",   int'(clk_en_o),   int'(m_en));
        check("div_busy_o", int'(div_busy_o), int'(m_busy));
        check("rst_n_o",    int'(rst_n_o),    int'(m_rst));
    endtask

    // one clk_i cycle: drive, edge, model, sample after the falling edge
    task automatic tick(input bit ld, input int d);
        div_i      = DIV_W'(d);
        div_load_i = ld;
        @(posedge clk_i);
        model_edge(ld, d);
        @(negedge clk_i);
        #1;
        div_load_i = 1'b0;
        check_outputs();
    endtask

    // release reset, check first enable edge and the release pulse index
    task automatic release_and_check(input bit ld, input int d);
        int k;
        int pulses;
        bit seen;
        reset_n = 1'b1;
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            k++;
            tick((k == 1) ? ld : 1'b0, d);
            if (clk_en_o) seen = 1;
        end
        check("first_en_edge", seen ? k : -1, STAGES + 1);
        pulses = 1;
        k = 0;
        while (!rst_n_o && k < 400) begin
            k++;
            tick(0, 0);
            if (clk_en_o) pulses++;
        end
        check("rst_release_pulse", rst_n_o ? pulses : -1, HOLD + 1);
    endtask

    // load a divisor, wait for it to apply, then measure one full period
    task automatic apply_and_measure(input int d, input int exp_len, input int exp_high);
        int k;
        int len;
        int high;
        tick(1, d);
        k = 0;
        while (div_busy_o && k < 600) begin
            k++;
            tick(0, 0);
        end
        check("busy_clears", int'(div_busy_o), 0);
        check("en_at_apply", int'(clk_en_o), 1);
        len  = 1;
        high = int'(clk_o);
        k = 0;
        while (k < 600) begin
            k++;
            tick(0, 0);
            if (clk_en_o) break;
            len++;
            high += int'(clk_o);
        end
        check("period_len",  len,  exp_len);
        check("period_high", high, exp_high);
    endtask

    typedef struct {
        int div;
        int exp_len;
        int exp_high;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{div: 0,  exp_len: 2,  exp_high: 1};
        vecs[1] = '{div: 1,  exp_len: 2,  exp_high: 1};
        vecs[2] = '{div: 5,  exp_len: 5,  exp_high: 2};
        vecs[3] = '{div: 4,  exp_len: 4,  exp_high: 2};
        vecs[4] = '{div: 7,  exp_len: 7,  exp_high: 3};
        vecs[5] = '{div: 2,  exp_len: 2,  exp_high: 1};
        vecs[6] = '{div: 9,  exp_len: 9,  exp_high: 4};
        vecs[7] = '{div: 13, exp_len: 13, exp_high: 6};

        // reset state
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        #1;

        // release at the default divisor
        release_and_check(0, 0);

        // divisor 5 requested while the synchroniser is still filling
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        #1;
        release_and_check(1, 5);
        apply_and_measure(5, 5, 2);

        // table of divisor loads, including clamped values
        foreach (vecs[i]) begin
            apply_and_measure(vecs[i].div, vecs[i].exp_len, vecs[i].exp_high);
        end

        // two loads inside one 13-cycle period: only the second applies
        tick(1, 6);
        apply_and_measure(9, 9, 4);

        // asynchronous reset in the middle of an N=9 period
        tick(0, 0);
        tick(0, 0);
        tick(0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        release_and_check(0, 0);
        apply_and_measure(DEF_DIV, DEF_DIV, DEF_DIV / 2);

        // randomized loads against the model
        for (int n = 0; n < 600; n++) begin
            bit ld;
            int d;
            ld = ($urandom_range(7, 0) == 0);
            d  = int'($urandom_range(15, 0));
            tick(ld, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
